// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
// Holds the FSM state encoding and the timer-width helper.
package led_stretch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Bits needed by a down-counter loaded with up to max(a,b).
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM dimmer for the ON phase of the LED pulse stretcher.
// Ports: sysclk/reset, start (entry into S_ON), on_next (next state is S_ON),
// led (registered, dimmed drive).
module led_pwm #(
    parameter int PWM_PERIOD = 16,
    parameter int PWM_DUTY   = 4
) (
    input  logic sysclk,
    input  logic reset,
    input  logic start,
    input  logic on_next,
    output logic led
);

    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    // Restart the phase on every blink so each one looks the same.
    always_comb begin
        cnt_n = cnt + 1'b1;
        if (start || (int'(cnt) == PWM_PERIOD - 1))
            cnt_n = '0;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            led <= 1'b0;
        end else begin
            cnt <= cnt_n;
            led <= on_next && (int'(cnt_n) < PWM_DUTY);
        end
    end

endmodule

// File: rtl/led_pulse_stretch.sv
// Stretches single-cycle event strobes into visible LED blinks with a
// mandatory dark gap, queueing events that arrive mid-blink.
// Ports: sysclk, reset (async, active-high), pulse_in (event strobe),
// led (LED drive), busy (not idle), pending (queued events),
// overflow (sticky, an event was dropped).
// Optional: define LED_STRETCH_PWM_EN to dim the LED with PWM during ON.
module led_pulse_stretch
    import led_stretch_pkg::*;
#(
    parameter int ON_COUNT    = 25_000_000,
    parameter int OFF_COUNT   = 12_500_000,
    parameter int PENDING_MAX = 7
`ifdef LED_STRETCH_PWM_EN
    ,
    parameter int PWM_PERIOD  = 16,
    parameter int PWM_DUTY    = 4
`endif
) (
    input  logic                               sysclk,
    input  logic                               reset,
    input  logic                               pulse_in,
    output logic                               led,
    output logic                               busy,
    output logic [$clog2(PENDING_MAX+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int TW = timer_width(ON_COUNT, OFF_COUNT);
    localparam int PW = $clog2(PENDING_MAX + 1);

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_COUNT - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_COUNT - 1);
    localparam logic [PW-1:0] P_MAX    = PW'(PENDING_MAX);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [PW-1:0] pending_n;
    logic          work, tdone, start;
    logic          inc, dec, drop;

    assign work  = (pending != '0) | pulse_in;
    assign tdone = (timer == '0);

    always_comb begin
        state_n = state;
        timer_n = timer;
        start   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (work) begin
                    start   = 1'b1;
                    state_n = S_ON;
                    timer_n = ON_LOAD;
                end
            end
            S_ON: begin
                if (tdone) begin
                    state_n = S_GAP;
                    timer_n = OFF_LOAD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_GAP: begin
                if (tdone) begin
                    if (work) begin
                        start   = 1'b1;
                        state_n = S_ON;
                        timer_n = ON_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

    // A start with an empty queue eats pulse_in directly, so that pulse
    // never enters the queue; otherwise the start drains one queued event.
    assign inc  = pulse_in && !(start && (pending == '0));
    assign dec  = start && (pending != '0);
    assign drop = inc && !dec && (pending == P_MAX);

    always_comb begin
        pending_n = pending;
        if (inc && !dec && !drop)
            pending_n = pending + 1'b1;
        else if (dec && !inc)
            pending_n = pending - 1'b1;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            pending  <= pending_n;
            if (drop)
                overflow <= 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

`ifdef LED_STRETCH_PWM_EN
    led_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .PWM_DUTY   (PWM_DUTY)
    ) u_pwm (
        .sysclk  (sysclk),
        .reset   (reset),
        .start   (start),
        .on_next (state_n == S_ON),
        .led     (led)
    );
`else
    assign led = (state == S_ON);
`endif

endmodule
